// File: rtl/mem_access_ctrl_pkg.sv
// ============================================================================
// Module : mem_access_ctrl_pkg
// Brief  : Bus widths, controller state encoding and alignment helper.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package mem_access_ctrl_pkg;

  localparam int DATA_BUS    = 32;
  localparam int ADDR_BUS    = 32;
  localparam int MEM_SEL_BUS = 4;

  typedef enum logic [1:0] {
    MAC_IDLE = 2'd0,
    MAC_REQ  = 2'd1,
    MAC_DONE = 2'd2
  } mac_state_e;

  // Word accesses need both low bits clear, half-word accesses need bit 0 clear.
  function automatic logic is_misaligned(input logic [1:0] addr_lo,
                                         input logic [MEM_SEL_BUS-1:0] sel);
    logic word_bad;
    logic half_bad;
    word_bad = (sel == 4'b1111) && (addr_lo != 2'b00);
    half_bad = ((sel == 4'b0011) || (sel == 4'b1100)) && addr_lo[0];
    return word_bad || half_bad;
  endfunction

endpackage

`default_nettype wire

// File: rtl/mem_access_ctrl_if.sv
// ============================================================================
// Module : mem_access_ctrl_if
// Brief  : Data-RAM req/ack bus between the MEM-stage initiator and the slave.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

interface mem_access_ctrl_if;
  import mem_access_ctrl_pkg::*;

  logic                   ram_en;
  logic [MEM_SEL_BUS-1:0] ram_write_en;
  logic [ADDR_BUS-1:0]    ram_addr;
  logic [DATA_BUS-1:0]    ram_write_data;
  logic                   ram_ack;
  logic [DATA_BUS-1:0]    ram_read_data;

  modport master (
    output ram_en, ram_write_en, ram_addr, ram_write_data,
    input  ram_ack, ram_read_data
  );

  modport slave (
    input  ram_en, ram_write_en, ram_addr, ram_write_data,
    output ram_ack, ram_read_data
  );

endinterface

`default_nettype wire

// File: rtl/mem_access_ctrl_timeout_counter.sv
// ============================================================================
// Module : mem_timeout_counter
// Brief  : Counts cycles spent waiting for ack; flags the last allowed cycle.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module mem_timeout_counter #(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  wire logic clk,
  input  wire logic rst,
  input  wire logic clear,
  input  wire logic inc,
  output logic      expired
);

  localparam int unsigned CW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CW-1:0] LAST = CW'(TIMEOUT_CYCLES - 1);

  logic [CW-1:0] cnt_q;

  // Asserted during the TIMEOUT_CYCLES-th waiting cycle.
  assign expired = inc && (cnt_q == LAST);

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      cnt_q <= '0;
    end else if (inc && !expired) begin
      cnt_q <= cnt_q + CW'(1);
    end
  end

endmodule

`default_nettype wire

// File: rtl/mem_access_ctrl.sv
// ============================================================================
// Module : mem_access_ctrl
// Brief  : MEM-stage data-RAM initiator with stall, read capture and timeout.
//          Optional alignment trap enabled by defining MEM_ALIGN_CHECK_EN.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module mem_access_ctrl
  import mem_access_ctrl_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  wire logic                   clk,
  input  wire logic                   rst,
  input  wire logic                   mem_read_flag_in,
  input  wire logic                   mem_write_flag_in,
  input  wire logic [ADDR_BUS-1:0]    mem_addr_in,
  input  wire logic [MEM_SEL_BUS-1:0] mem_sel_in,
  input  wire logic [DATA_BUS-1:0]    mem_write_data_in,
  input  wire logic                   flush,
  input  wire logic                   stall_next_stage,
  mem_access_ctrl_if.master           bus,
  output logic      [DATA_BUS-1:0]    ram_read_data_out,
  output logic                        stall_request,
  output logic                        bus_error_out,
  output logic                        addr_error_out,
  output logic      [ADDR_BUS-1:0]    bad_vaddr_out
);

  mac_state_e             state_q, state_d;
  logic                   ram_en_q, ram_en_d;
  logic [MEM_SEL_BUS-1:0] ram_we_q, ram_we_d;
  logic [ADDR_BUS-1:0]    ram_addr_q, ram_addr_d;
  logic [DATA_BUS-1:0]    ram_wdata_q, ram_wdata_d;
  logic [DATA_BUS-1:0]    rdata_q, rdata_d;
  logic                   berr_q, berr_d;
  logic                   aerr_q, aerr_d;
  logic [ADDR_BUS-1:0]    badv_q, badv_d;
  logic [ADDR_BUS-1:0]    vaddr_q, vaddr_d;
  logic                   is_wr_q, is_wr_d;
  logic                   flushed_q, flushed_d;

  logic access;
  logic misaligned;
  logic flush_any;
  logic cnt_clear;
  logic cnt_inc;
  logic expired;

  assign access    = (mem_read_flag_in | mem_write_flag_in) & ~flush;
  assign flush_any = flushed_q | flush;
  assign cnt_inc   = (state_q == MAC_REQ);
  assign cnt_clear = (state_q != MAC_REQ);

`ifdef MEM_ALIGN_CHECK_EN
  assign misaligned = is_misaligned(mem_addr_in[1:0], mem_sel_in);
`else
  assign misaligned = 1'b0;
`endif

  mem_timeout_counter #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_timeout (
    .clk     (clk),
    .rst     (rst),
    .clear   (cnt_clear),
    .inc     (cnt_inc),
    .expired (expired)
  );

  always_comb begin
    state_d       = state_q;
    ram_en_d      = ram_en_q;
    ram_we_d      = ram_we_q;
    ram_addr_d    = ram_addr_q;
    ram_wdata_d   = ram_wdata_q;
    rdata_d       = rdata_q;
    berr_d        = 1'b0;
    aerr_d        = 1'b0;
    badv_d        = badv_q;
    vaddr_d       = vaddr_q;
    is_wr_d       = is_wr_q;
    flushed_d     = flushed_q;
    stall_request = 1'b0;

    case (state_q)
      MAC_IDLE: begin
        if (access) begin
          stall_request = 1'b1;
          if (misaligned) begin
            aerr_d  = 1'b1;
            badv_d  = mem_addr_in;
            rdata_d = '0;
            state_d = MAC_DONE;
          end else begin
            ram_en_d    = 1'b1;
            ram_addr_d  = {mem_addr_in[ADDR_BUS-1:2], 2'b00};
            ram_we_d    = mem_write_flag_in ? mem_sel_in : '0;
            ram_wdata_d = mem_write_data_in;
            vaddr_d     = mem_addr_in;
            is_wr_d     = mem_write_flag_in;
            flushed_d   = 1'b0;
            state_d     = MAC_REQ;
          end
        end
      end

      MAC_REQ: begin
        stall_request = 1'b1;
        flushed_d     = flush_any;
        // Ack is checked first so it wins over a coincident timeout.
        if (bus.ram_ack || expired) begin
          ram_en_d  = 1'b0;
          ram_we_d  = '0;
          flushed_d = 1'b0;
          if (flush_any) begin
            state_d = MAC_IDLE;
          end else if (bus.ram_ack) begin
            rdata_d = is_wr_q ? '0 : bus.ram_read_data;
            state_d = MAC_DONE;
          end else begin
            rdata_d = '0;
            berr_d  = 1'b1;
            badv_d  = vaddr_q;
            state_d = MAC_DONE;
          end
        end
      end

      MAC_DONE: begin
        if (!stall_next_stage) begin
          state_d = MAC_IDLE;
        end
      end

      default: state_d = MAC_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= MAC_IDLE;
      ram_en_q    <= 1'b0;
      ram_we_q    <= '0;
      ram_addr_q  <= '0;
      ram_wdata_q <= '0;
      rdata_q     <= '0;
      berr_q      <= 1'b0;
      aerr_q      <= 1'b0;
      badv_q      <= '0;
      vaddr_q     <= '0;
      is_wr_q     <= 1'b0;
      flushed_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      ram_en_q    <= ram_en_d;
      ram_we_q    <= ram_we_d;
      ram_addr_q  <= ram_addr_d;
      ram_wdata_q <= ram_wdata_d;
      rdata_q     <= rdata_d;
      berr_q      <= berr_d;
      aerr_q      <= aerr_d;
      badv_q      <= badv_d;
      vaddr_q     <= vaddr_d;
      is_wr_q     <= is_wr_d;
      flushed_q   <= flushed_d;
    end
  end

  assign bus.ram_en         = ram_en_q;
  assign bus.ram_write_en   = ram_we_q;
  assign bus.ram_addr       = ram_addr_q;
  assign bus.ram_write_data = ram_wdata_q;
  assign ram_read_data_out  = rdata_q;
  assign bus_error_out      = berr_q;
  assign addr_error_out     = aerr_q;
  assign bad_vaddr_out      = badv_q;

endmodule

`default_nettype wire

// File: tb/tb_mem_access_ctrl.sv
// ============================================================================
// Module : tb_mem_access_ctrl
// Brief  : Directed plus randomized transactions against a transaction-level
//          model of the MEM-stage data-RAM initiator (TIMEOUT_CYCLES = 4).
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_mem_access_ctrl;

  localparam int T = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        mem_read_flag_in = 1'b0;
  logic        mem_write_flag_in = 1'b0;
  logic [31:0] mem_addr_in = '0;
  logic [3:0]  mem_sel_in = '0;
  logic [31:0] mem_write_data_in = '0;
  logic        flush = 1'b0;
  logic        stall_next_stage = 1'b0;
  logic [31:0] ram_read_data_out;
  logic        stall_request;
  logic        bus_error_out;
  logic        addr_error_out;
  logic [31:0] bad_vaddr_out;

  int checks = 0;
  int errors = 0;
  logic [31:0] exp_badv = '0;

  mem_access_ctrl_if bus_if ();

  mem_access_ctrl #(.TIMEOUT_CYCLES(T)) dut (
    .clk               (clk),
    .rst               (rst),
    .mem_read_flag_in  (mem_read_flag_in),
    .mem_write_flag_in (mem_write_flag_in),
    .mem_addr_in       (mem_addr_in),
    .mem_sel_in        (mem_sel_in),
    .mem_write_data_in (mem_write_data_in),
    .flush             (flush),
    .stall_next_stage  (stall_next_stage),
    .bus               (bus_if.master),
    .ram_read_data_out (ram_read_data_out),
    .stall_request     (stall_request),
    .bus_error_out     (bus_error_out),
    .addr_error_out    (addr_error_out),
    .bad_vaddr_out     (bad_vaddr_out)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, got, exp);
    end
  endtask

  function automatic bit misal(input logic [31:0] a, input logic [3:0] s);
`ifdef MEM_ALIGN_CHECK_EN
    logic [1:0] lo;
    lo = a[1:0];
    return ((s == 4'hF) && (lo != 2'b00)) || (((s == 4'h3) || (s == 4'hC)) && lo[0]);
`else
    return 1'b0;
`endif
  endfunction

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  // Entered and left one time unit after a rising edge, with the DUT idle.
  // waits = wait cycles before ack; a flushed access ends with the DUT back in
  // IDLE, which the next call observes through the issue-cycle stall.
  task automatic do_access(input bit wr, input logic [31:0] addr, input logic [3:0] sel,
                           input logic [31:0] wd, input int waits, input logic [31:0] rd,
                           input int hold, input bit fl_in);
    bit mis, timed, fl;
    int len;
    logic [31:0] exp_rd;
    mis   = misal(addr, sel);
    fl    = fl_in && !mis;
    timed = (waits + 1) > T;
    len   = timed ? T : waits + 1;
    exp_rd = (mis || timed || wr) ? 32'h0 : rd;

    chk("idle_ram_en", bus_if.ram_en, 0);
    chk("idle_bus_err", bus_error_out, 0);
    chk("idle_addr_err", addr_error_out, 0);
    chk("idle_bad_vaddr", bad_vaddr_out, exp_badv);
    mem_read_flag_in  = !wr;
    mem_write_flag_in = wr;
    mem_addr_in       = addr;
    mem_sel_in        = sel;
    mem_write_data_in = wd;
    #1;
    chk("issue_stall", stall_request, 1);
    next_cycle();
    mem_read_flag_in  = 1'b0;
    mem_write_flag_in = 1'b0;

    if (!mis) begin
      for (int k = 1; k <= len; k++) begin
        chk("req_ram_en", bus_if.ram_en, 1);
        chk("req_ram_addr", bus_if.ram_addr, {addr[31:2], 2'b00});
        chk("req_write_en", bus_if.ram_write_en, wr ? sel : 4'h0);
        chk("req_write_data", bus_if.ram_write_data, wd);
        bus_if.ram_ack       = (k == waits + 1);
        bus_if.ram_read_data = (k == waits + 1) ? rd : $urandom;
        flush                = fl && (k == 1);
        #1;
        chk("req_stall", stall_request, 1);
        next_cycle();
        bus_if.ram_ack = 1'b0;
        flush          = 1'b0;
      end
      if (fl) begin
        chk("flushed_ram_en", bus_if.ram_en, 0);
        chk("flushed_no_bus_err", bus_error_out, 0);
        return;
      end
    end
    if (timed || mis) exp_badv = addr;

    for (int j = 0; j <= hold; j++) begin
      chk("done_ram_en", bus_if.ram_en, 0);
      chk("done_rdata", ram_read_data_out, exp_rd);
      chk("done_bus_err", bus_error_out, (j == 0) && timed && !mis);
      chk("done_addr_err", addr_error_out, (j == 0) && mis);
      chk("done_bad_vaddr", bad_vaddr_out, exp_badv);
      stall_next_stage = (j < hold);
      mem_read_flag_in = 1'b1;
      #1;
      chk("done_stall", stall_request, 0);
      next_cycle();
    end
    mem_read_flag_in = 1'b0;
    stall_next_stage = 1'b0;
  endtask

  initial begin
    logic [3:0] sels [7];
    sels = '{4'hF, 4'h3, 4'hC, 4'h1, 4'h2, 4'h4, 4'h8};
    bus_if.ram_ack       = 1'b0;
    bus_if.ram_read_data = '0;

    next_cycle();
    next_cycle();
    chk("rst_ram_en", bus_if.ram_en, 0);
    chk("rst_write_en", bus_if.ram_write_en, 0);
    chk("rst_ram_addr", bus_if.ram_addr, 0);
    chk("rst_write_data", bus_if.ram_write_data, 0);
    chk("rst_rdata", ram_read_data_out, 0);
    chk("rst_stall", stall_request, 0);
    chk("rst_bus_err", bus_error_out, 0);
    chk("rst_addr_err", addr_error_out, 0);
    chk("rst_bad_vaddr", bad_vaddr_out, 0);
    rst = 1'b0;
    next_cycle();

    do_access(0, 32'h100, 4'hF, 32'h0, 0, 32'hDEADBEEF, 0, 0);
    do_access(1, 32'h206, 4'hC, 32'h12340000, 3, 32'h5555AAAA, 0, 0);
    do_access(0, 32'h300, 4'hF, 32'h0, 1, 32'hCAFEF00D, 3, 0);
    do_access(0, 32'h400, 4'hF, 32'h0, 50, 32'h11111111, 1, 0);
    do_access(1, 32'h500, 4'hF, 32'hA5A5A5A5, 2, 32'h0, 0, 1);
    do_access(0, 32'h103, 4'hF, 32'h0, 0, 32'h77777777, 1, 0);
    do_access(1, 32'h600, 4'h3, 32'h0000BEEF, 10, 32'h0, 0, 1);

    // Reset while a request is outstanding.
    mem_read_flag_in = 1'b1;
    mem_addr_in      = 32'h704;
    mem_sel_in       = 4'hF;
    #1;
    chk("rstmid_issue_stall", stall_request, 1);
    next_cycle();
    mem_read_flag_in = 1'b0;
    chk("rstmid_req_en", bus_if.ram_en, 1);
    next_cycle();
    rst = 1'b1;
    next_cycle();
    chk("rstmid_ram_en", bus_if.ram_en, 0);
    chk("rstmid_write_en", bus_if.ram_write_en, 0);
    chk("rstmid_ram_addr", bus_if.ram_addr, 0);
    chk("rstmid_rdata", ram_read_data_out, 0);
    chk("rstmid_stall", stall_request, 0);
    chk("rstmid_bad_vaddr", bad_vaddr_out, 0);
    rst = 1'b0;
    exp_badv = '0;
    next_cycle();

    for (int n = 0; n < 60; n++) begin
      int r, w;
      r = $urandom_range(0, 9);
      w = (r < 2) ? $urandom_range(4, 7) : $urandom_range(0, 3);
      do_access(1'($urandom_range(0, 1)), $urandom, sels[$urandom_range(0, 6)], $urandom,
                w, $urandom, $urandom_range(0, 2), $urandom_range(0, 5) == 0);
    end
    do_access(0, 32'h800, 4'hF, 32'h0, 0, 32'h0BADF00D, 0, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
